// File: rtl/fifo_push_pop_arbiter.sv
// fifo_push_pop_arbiter: round-robin push arbitration and pop granting in
// front of a FIFO. The controller tracks FIFO occupancy itself, so grants are
// decided one cycle ahead of the registered push/pop strobes the FIFO sees.
module fifo_push_pop_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic                         clear_err,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         pop_req,
    output logic                         pop_gnt,
    output logic                         rd_valid,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         push,
    output logic                         pop,
    output logic [WIDTH-1:0]             data_in,
    input  logic [WIDTH-1:0]             data_out,
    input  logic                         full,
    input  logic                         empty,
    input  logic                         error,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err_flag
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
    logic [WIDTH-1:0]   dataIn_q, dataIn_d;
    logic               push_q;
    logic               pop_q;
    logic               rdValid_q;

    logic               winFound;
    logic [PTR_W-1:0]   winIdx;
    logic [WIDTH-1:0]   winData;
    logic [NUM_REQ-1:0] gntVec;
    logic               popGnt;
    logic               pushOk;
    logic               pushXfer;
    logic               popXfer;
    logic [SUM_W-1:0]   candSum;
    logic [PTR_W-1:0]   candIdx;

    // Next-state logic: error wins over en, HALT is left only through clear_err.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (error) begin
                    state_d = HALT;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (error) begin
                    state_d = HALT;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (clear_err) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin search: first asserted request at or above rrPtr_q, wrapping.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        candSum  = '0;
        candIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            candSum = {1'b0, rrPtr_q} + SUM_W'(k);
            if (candSum >= SUM_W'(NUM_REQ)) begin
                candSum = candSum - SUM_W'(NUM_REQ);
            end
            candIdx = candSum[PTR_W-1:0];
            if (!winFound && req[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Data mux selecting the winning requester's slice of req_data.
    always_comb begin
        winData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == PTR_W'(i)) begin
                winData = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grants: pops need a non-empty tracked count; pushes also stop as soon as en drops,
    // and a full FIFO only accepts a push when a pop is granted in the same cycle.
    always_comb begin
        popGnt = (state_q == RUN) && (count_q != '0);
        pushOk = (state_q == RUN) && en &&
                 ((count_q < FULL_LVL) || (popGnt && pop_req));
        gntVec = '0;
        if (pushOk && winFound) begin
            gntVec[winIdx] = 1'b1;
        end
        pushXfer = |(req & gntVec);
        popXfer  = pop_req && popGnt;
    end

    // Occupancy, pointer and write-data updates taken at transfer edges.
    always_comb begin
        count_d  = count_q;
        rrPtr_d  = rrPtr_q;
        dataIn_d = dataIn_q;
        if (pushXfer && !popXfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!pushXfer && popXfer) begin
            count_d = count_q - CNT_W'(1);
        end
        if (pushXfer) begin
            rrPtr_d  = (winIdx == LAST_REQ) ? '0 : winIdx + PTR_W'(1);
            dataIn_d = winData;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any push or pop still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            rrPtr_q   <= '0;
            dataIn_q  <= '0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            rdValid_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rrPtr_q   <= rrPtr_d;
            dataIn_q  <= dataIn_d;
            push_q    <= pushXfer;
            pop_q     <= popXfer;
            rdValid_q <= pop;
        end
    end

    // The FIFO flags only act as a safety net here: with a consistent FIFO the
    // tracked count already keeps push off a full FIFO and pop off an empty one.
    assign push     = push_q && !(full && !pop_q);
    assign pop      = pop_q && !empty;
    assign data_in  = dataIn_q;
    assign rd_valid = rdValid_q;
    assign rd_data  = data_out;
    assign gnt      = gntVec;
    assign pop_gnt  = popGnt;
    assign count    = count_q;
    assign err_flag = (state_q == HALT);

endmodule

// File: doc/fifo_push_pop_arbiter.md
FIFO_PUSH_POP_ARBITER -- requirements
Module: fifo_push_pop_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of push requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 16: data word width, equal to the FIFO word_t width.
REQ-003 SHALL have parameter DEPTH, default 16: FIFO capacity in words, equal to the FIFO FULL level.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable.
- clear_err  in  1  one-cycle pulse that releases HALT.
- req  in  NUM_REQ  push request per requester.
- req_data  in  NUM_REQ*WIDTH  push data; requester i uses slice i.
- gnt  out  NUM_REQ  push grant, combinational, one-hot or zero.
- pop_req  in  1  consumer read request.
- pop_gnt  out  1  read grant, combinational.
- rd_valid  out  1  rd_data holds the popped word.
- rd_data  out  WIDTH  read data, pass-through of the FIFO data_out.
- push  out  1  FIFO push, registered.
- pop  out  1  FIFO pop, registered.
- data_in  out  WIDTH  FIFO write data, registered.
- data_out  in  WIDTH  FIFO read data.
- full, empty, error  in  1 each  FIFO status flags.
- count  out  $clog2(DEPTH+1)  tracked occupancy.
- err_flag  out  1  controller is in HALT.

Function
REQ-005 SHALL implement a state machine with states IDLE, RUN and HALT; reset state is IDLE.
REQ-006 SHALL make these transitions: IDLE->RUN when en=1; RUN->IDLE when en=0; RUN or IDLE->HALT when error=1 is sampled; HALT->IDLE on clear_err=1.
REQ-007 SHALL keep all gnt bits and pop_gnt at 0 in IDLE and in HALT.
REQ-008 SHALL complete a push transfer at a rising edge only when req[i]=1 and gnt[i]=1; the requester holds req and data until that edge.
REQ-009 SHALL complete a pop transfer at a rising edge only when pop_req=1 and pop_gnt=1.
REQ-010 SHALL make pop_gnt equal to (state==RUN and count>0).
REQ-011 SHALL allow a push grant in RUN only when count<DEPTH, or when count==DEPTH and pop_gnt&&pop_req is high in the same cycle.
REQ-012 SHALL select the push winner round-robin: the first asserted req at or above rr_ptr, wrapping modulo NUM_REQ.
REQ-013 SHALL set rr_ptr=(w+1) mod NUM_REQ after a push transfer by requester w; rr_ptr is unchanged otherwise.
REQ-014 SHALL, at the edge after a push transfer, register push=1 and data_in=req_data slice w for exactly one cycle; otherwise push=0 and data_in holds its last value.
REQ-015 SHALL, at the edge after a pop transfer, register pop=1 for exactly one cycle.
REQ-016 SHALL assert rd_valid one cycle after pop=1, i.e. two cycles after the pop transfer edge; rd_data=data_out while rd_valid=1.
REQ-017 SHALL update count at transfer edges: +1 for a push only, -1 for a pop only, unchanged for both or neither.
REQ-018 SHALL never drive push=1 with full=1 and pop=0, and never drive pop=1 with empty=1.
REQ-019 SHALL drive err_flag=1 exactly while in HALT.
REQ-020 SHALL keep count and rr_ptr unchanged on HALT entry and on HALT exit.
REQ-021 SHALL let pushes and pops issued before HALT entry complete normally; no new transfers start while in HALT.
REQ-022 SHALL give error priority over en when both change in the same cycle.

Reset
REQ-023 SHALL, while reset_n=0, force asynchronously: state=IDLE, gnt=0, pop_gnt=0, push=0, pop=0, data_in=0, rd_valid=0, count=0, rr_ptr=0, err_flag=0.
REQ-024 SHALL, when reset is asserted mid-transfer, drop any registered push or pop immediately; the lost transfer is not counted.
REQ-025 SHALL leave IDLE no earlier than the first rising edge after reset_n deasserts with en=1.

Verification
REQ-026 Bench SHALL cover: reset, en=1, req=4'b1111 held -> grants in order 0,1,2,3,0; push pulses carry the matching data; count rises by 1 per cycle.
REQ-027 Bench SHALL cover: fill to count=16, req[2]=1 -> gnt=0; then pop_req=1 in the same cycle -> gnt[2]=1 and pop_gnt=1 together, count stays 16, push and pop both high on the next cycle.
REQ-028 Bench SHALL cover: count=0, pop_req=1 -> pop_gnt=0 and pop never asserted; after a single push, pop_gnt=1 and rd_valid high 2 cycles after the pop transfer with rd_data equal to the pushed word.
REQ-029 Bench SHALL cover: force error=1 for one cycle in RUN -> err_flag=1 and all grants 0 from the next cycle; clear_err pulse -> IDLE, then RUN with count preserved.
REQ-030 Bench SHALL cover: reset_n=0 during a cycle with push=1 -> push=0 and count=0 immediately, without waiting for a clock edge.
REQ-031 Bench SHALL cover: en=0 during continuous requests -> no grants from that cycle on; en=1 again -> grants resume at the saved rr_ptr.
